// File: rtl/thread_state_mp.sv
// Multi-port thread-state store: N_WR buffered write channels committed one per
// cycle by fixed priority, N_RD read channels (sync or async), reset-time zero sweep.

module thread_state_rd_port #(
  parameter int W     = 16,
  parameter bit ASYNC = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] word_i,
  output logic [W-1:0] data_o
);
  if (ASYNC) begin : g_async
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RESET;
    assign data_o = word_i;
  end else begin : g_sync
    logic [W-1:0] data_d, data_q;
    always_comb data_d = word_i;
    always_ff @(posedge CLK) begin
      if (RESET) data_q <= '0;
      else       data_q <= data_d;
    end
    assign data_o = data_q;
  end
endmodule

module thread_state_wr_ch #(
  parameter int NUM_W       = 4,
  parameter int STATE_WIDTH = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ready_i,
  input  logic                   grant_i,
  input  logic                   wr_en_i,
  input  logic [NUM_W-1:0]       wr_num_i,
  input  logic [STATE_WIDTH-1:0] wr_state_i,
  output logic                   pending_o,
  output logic [NUM_W-1:0]       hold_num_o,
  output logic [STATE_WIDTH-1:0] hold_state_o,
  output logic                   ovf_o
);
  logic                   pending_d, pending_q;
  logic [NUM_W-1:0]       num_d, num_q;
  logic [STATE_WIDTH-1:0] state_d, state_q;

  // A granted slot frees up this cycle, so it may reload without overflowing.
  assign ovf_o = wr_en_i & (~ready_i | (pending_q & ~grant_i));

  always_comb begin
    pending_d = pending_q;
    num_d     = num_q;
    state_d   = state_q;
    if (wr_en_i && !ovf_o) begin
      pending_d = 1'b1;
      num_d     = wr_num_i;
      state_d   = wr_state_i;
    end else if (grant_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= 1'b0;
      num_q     <= '0;
      state_q   <= '0;
    end else begin
      pending_q <= pending_d;
      num_q     <= num_d;
      state_q   <= state_d;
    end
  end

  assign pending_o    = pending_q;
  assign hold_num_o   = num_q;
  assign hold_state_o = state_q;
endmodule

module thread_state_mp #(
  parameter int              N_THREADS   = 16,
  parameter int              NUM_W       = $clog2(N_THREADS),
  parameter int              STATE_WIDTH = 16,
  parameter int              N_WR        = 4,
  parameter int              N_RD        = 4,
  parameter logic [N_RD-1:0] RD_ASYNC    = 'b0001,
  parameter int              RD_PER_COPY = 2
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [N_WR-1:0]               wr_en,
  input  logic [N_WR*NUM_W-1:0]         wr_num,
  input  logic [N_WR*STATE_WIDTH-1:0]   wr_state,
  input  logic [N_RD*NUM_W-1:0]         rd_num,
  output logic [N_RD*STATE_WIDTH-1:0]   rd_state,
  output logic                          ready,
  output logic                          err,
  output logic [2:0]                    err_ch
);
  localparam int N_COPY = (N_RD + RD_PER_COPY - 1) / RD_PER_COPY;

  logic [STATE_WIDTH-1:0] mem [N_COPY][N_THREADS];

  logic [N_WR-1:0]                  pending, grant, ovf;
  logic [N_WR-1:0][NUM_W-1:0]       hold_num;
  logic [N_WR-1:0][STATE_WIDTH-1:0] hold_state;
  logic [N_RD-1:0][STATE_WIDTH-1:0] rd_word, rd_data;

  logic                   mem_we;
  logic [NUM_W-1:0]       mem_addr;
  logic [STATE_WIDTH-1:0] mem_wdata;

  logic             ready_d, ready_q, err_d, err_q;
  logic [2:0]       err_ch_d, err_ch_q;
  logic [NUM_W-1:0] sweep_cnt_d, sweep_cnt_q;

  for (genvar k = 0; k < N_WR; k++) begin : g_wr
    thread_state_wr_ch #(.NUM_W(NUM_W), .STATE_WIDTH(STATE_WIDTH)) u_ch (
      .CLK(CLK), .RESET(RESET), .ready_i(ready_q), .grant_i(grant[k]),
      .wr_en_i(wr_en[k]), .wr_num_i(wr_num[k*NUM_W +: NUM_W]),
      .wr_state_i(wr_state[k*STATE_WIDTH +: STATE_WIDTH]),
      .pending_o(pending[k]), .hold_num_o(hold_num[k]),
      .hold_state_o(hold_state[k]), .ovf_o(ovf[k])
    );
  end

  // Single write port shared by the sweep and the arbiter; sweep owns it until ready.
  always_comb begin
    grant     = '0;
    mem_we    = 1'b0;
    mem_addr  = sweep_cnt_q;
    mem_wdata = '0;
    if (!ready_q) begin
      mem_we = 1'b1;
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (pending[k] && !mem_we) begin
          grant[k]  = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = hold_num[k];
          mem_wdata = hold_state[k];
        end
      end
    end
  end

  always_comb begin
    sweep_cnt_d = sweep_cnt_q;
    ready_d     = ready_q;
    err_d       = err_q;
    err_ch_d    = err_ch_q;
    if (!ready_q) begin
      sweep_cnt_d = sweep_cnt_q + NUM_W'(1);
      if (sweep_cnt_q == NUM_W'(N_THREADS - 1)) ready_d = 1'b1;
    end
    if (|ovf) begin
      err_d = 1'b1;
      if (!err_q) begin
        for (int k = N_WR - 1; k >= 0; k--)
          if (ovf[k]) err_ch_d = 3'(k);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sweep_cnt_q <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      err_ch_q    <= '0;
    end else begin
      sweep_cnt_q <= sweep_cnt_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      err_ch_q    <= err_ch_d;
    end
  end

  // Every replica takes the same write; each serves RD_PER_COPY read channels.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int c = 0; c < N_COPY; c++) mem[c][mem_addr] <= mem_wdata;
    end
  end

  for (genvar r = 0; r < N_RD; r++) begin : g_rd
    assign rd_word[r] = mem[r / RD_PER_COPY][rd_num[r*NUM_W +: NUM_W]];
    thread_state_rd_port #(.W(STATE_WIDTH), .ASYNC(RD_ASYNC[r])) u_rd (
      .CLK(CLK), .RESET(RESET), .word_i(rd_word[r]), .data_o(rd_data[r])
    );
    assign rd_state[r*STATE_WIDTH +: STATE_WIDTH] = rd_data[r];
  end

  assign ready  = ready_q;
  assign err    = err_q;
  assign err_ch = err_ch_q;
endmodule

// File: tb/tb_thread_state_mp.sv
// Self-checking bench for thread_state_mp: directed vector table, hand-written
// reset/sweep sequences, and randomized traffic against a behavioural model.

module tb_thread_state_mp;
  localparam int NT = 16, NW = 4, SW = 16, NWR = 4, NRD = 4;
  localparam logic [NRD-1:0] RDA = 4'b0001;

  logic                CLK = 1'b0;
  logic                RESET;
  logic [NWR-1:0]      wr_en;
  logic [NWR*NW-1:0]   wr_num;
  logic [NWR*SW-1:0]   wr_state;
  logic [NRD*NW-1:0]   rd_num;
  logic [NRD*SW-1:0]   rd_state;
  logic                ready, err;
  logic [2:0]          err_ch;

  always #5 CLK = ~CLK;

  thread_state_mp #(
    .N_THREADS(NT), .NUM_W(NW), .STATE_WIDTH(SW), .N_WR(NWR), .N_RD(NRD),
    .RD_ASYNC(RDA), .RD_PER_COPY(2)
  ) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_num(wr_num), .wr_state(wr_state),
    .rd_num(rd_num), .rd_state(rd_state), .ready(ready), .err(err), .err_ch(err_ch)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: memory array, one-deep per-channel buffers, sticky error.
  logic [SW-1:0] m_mem [NT];
  bit            m_pend [NWR];
  int            m_hnum [NWR];
  logic [SW-1:0] m_hst  [NWR];
  bit            m_ready, m_err;
  int            m_errch, m_cnt;
  bit            s_known [NRD];
  logic [SW-1:0] s_exp   [NRD];

  task automatic model_step();
    int g, first;
    if (RESET) begin
      m_ready = 0; m_err = 0; m_errch = 0; m_cnt = 0;
      for (int k = 0; k < NWR; k++) m_pend[k] = 0;
      for (int r = 0; r < NRD; r++) begin s_known[r] = 1; s_exp[r] = '0; end
      return;
    end
    for (int r = 0; r < NRD; r++) begin
      s_known[r] = m_ready;
      s_exp[r]   = m_mem[rd_num[r*NW +: NW]];
    end
    first = -1;
    if (!m_ready) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NT) m_ready = 1;
      for (int k = 0; k < NWR; k++) if (wr_en[k] && first < 0) first = k;
    end else begin
      g = -1;
      for (int k = 0; k < NWR; k++) if (m_pend[k] && g < 0) g = k;
      if (g >= 0) m_mem[m_hnum[g]] = m_hst[g];
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k]) begin
          if (m_pend[k] && k != g) begin
            if (first < 0) first = k;
          end else begin
            m_pend[k] = 1;
            m_hnum[k] = int'(wr_num[k*NW +: NW]);
            m_hst[k]  = wr_state[k*SW +: SW];
          end
        end else if (k == g) begin
          m_pend[k] = 0;
        end
      end
    end
    if (first >= 0) begin
      if (!m_err) m_errch = first;
      m_err = 1;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK); #1;
    chk("ready", ready, m_ready);
    chk("err", err, m_err);
    chk("err_ch", err_ch, m_errch);
    for (int r = 0; r < NRD; r++) begin
      if (RDA[r]) begin
        if (m_ready) chk("async_rd", rd_state[r*SW +: SW], m_mem[rd_num[r*NW +: NW]]);
      end else if (s_known[r]) begin
        chk("sync_rd", rd_state[r*SW +: SW], s_exp[r]);
      end
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin step(); n++; end
  endtask

  typedef struct {
    logic [3:0]  en;
    logic [15:0] num;
    logic [63:0] st;
    logic [15:0] rdn;
    logic [15:0] e0;
    logic [15:0] e1;
    logic        e_err;
    logic [2:0]  e_ch;
  } vec_t;

  vec_t vt [18];

  initial begin
    int n;
    RESET = 1; wr_en = '0; wr_num = '0; wr_state = '0; rd_num = '0;

    vt[0]  = '{4'b0001, 16'h0005, 64'h2A, 16'h0055, 16'h00, 16'h00, 0, 0};
    vt[1]  = '{4'b0000, 16'h0000, 64'h0,  16'h0055, 16'h2A, 16'h00, 0, 0};
    vt[2]  = '{4'b0000, 16'h0000, 64'h0,  16'h0055, 16'h2A, 16'h2A, 0, 0};
    vt[3]  = '{4'b1011, 16'h3021, 64'h0033_0000_0022_0011, 16'h0021, 16'h00, 16'h00, 0, 0};
    vt[4]  = '{4'b0000, 16'h0000, 64'h0,  16'h0012, 16'h00, 16'h00, 0, 0};
    vt[5]  = '{4'b0000, 16'h0000, 64'h0,  16'h0013, 16'h00, 16'h11, 0, 0};
    vt[6]  = '{4'b0000, 16'h0000, 64'h0,  16'h0023, 16'h33, 16'h22, 0, 0};
    vt[7]  = '{4'b0000, 16'h0000, 64'h0,  16'h0031, 16'h11, 16'h33, 0, 0};
    vt[8]  = '{4'b0101, 16'h0707, 64'h0000_0002_0000_0001, 16'h0077, 16'h00, 16'h00, 0, 0};
    vt[9]  = '{4'b0000, 16'h0000, 64'h0,  16'h0077, 16'h01, 16'h00, 0, 0};
    vt[10] = '{4'b0000, 16'h0000, 64'h0,  16'h0077, 16'h02, 16'h01, 0, 0};
    vt[11] = '{4'b0000, 16'h0000, 64'h0,  16'h0077, 16'h02, 16'h02, 0, 0};
    vt[12] = '{4'b0011, 16'h0098, 64'h00B1_00A0, 16'h0089, 16'h00, 16'h00, 0, 0};
    vt[13] = '{4'b0011, 16'h009A, 64'h00B2_00A1, 16'h0089, 16'h00, 16'h00, 1, 1};
    vt[14] = '{4'b0001, 16'h000B, 64'h00A2, 16'h0089, 16'h00, 16'hA0, 1, 1};
    vt[15] = '{4'b0000, 16'h0000, 64'h0,  16'h0089, 16'h00, 16'hA0, 1, 1};
    vt[16] = '{4'b0000, 16'h0000, 64'h0,  16'h0089, 16'hB1, 16'hA0, 1, 1};
    vt[17] = '{4'b0000, 16'h0000, 64'h0,  16'h00A9, 16'hB1, 16'hA1, 1, 1};

    // Power-on reset and first sweep.
    step(); step();
    RESET = 0;
    wait_ready(n);
    chk("sweep_len_first", n, 16);

    // Preload nonzero words, then reset and confirm the sweep clears them.
    for (int i = 0; i < NT; i++) begin
      wr_en = 4'b0001; wr_num = 16'(i); wr_state = 64'(16'hA500 | i);
      step();
    end
    wr_en = '0;
    step(); step();
    rd_num = {4{4'h5}};
    step();
    chk("preload_rd", rd_state[15:0], 16'hA505);
    RESET = 1; step(); RESET = 0;
    wait_ready(n);
    chk("sweep_len_init", n, 16);
    for (int t = 0; t < NT; t++) begin
      rd_num = {4{4'(t)}};
      step();
      for (int r = 0; r < NRD; r++) chk("init_zero", rd_state[r*SW +: SW], 0);
    end

    // Write during sweep flags an overflow; reset mid-sweep restarts and clears it.
    RESET = 1; step(); RESET = 0;
    wr_en = 4'b0100; wr_num = 16'h0300; wr_state = 64'h0000_0077_0000_0000;
    step();
    wr_en = '0;
    chk("sweep_wr_err", err, 1);
    chk("sweep_wr_err_ch", err_ch, 2);
    for (int i = 0; i < 8; i++) step();
    RESET = 1; step(); RESET = 0;
    chk("midsweep_err_clr", err, 0);
    chk("midsweep_not_ready", ready, 0);
    wait_ready(n);
    chk("sweep_len_restart", n, 16);

    // Directed vectors: single write, contention, same-thread collision, overflow.
    for (int i = 0; i < 18; i++) begin
      wr_en = vt[i].en; wr_num = vt[i].num; wr_state = vt[i].st; rd_num = vt[i].rdn;
      step();
      chk($sformatf("vec%0d_rd0", i), rd_state[15:0], vt[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_state[31:16], vt[i].e1);
      chk($sformatf("vec%0d_err", i), err, vt[i].e_err);
      chk($sformatf("vec%0d_err_ch", i), err_ch, vt[i].e_ch);
    end

    // Randomized traffic with occasional resets.
    wr_en = '0;
    RESET = 1; step(); RESET = 0;
    wait_ready(n);
    chk("sweep_len_rand", n, 16);
    for (int c = 0; c < 600; c++) begin
      RESET = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < NWR; k++) wr_en[k] = ($urandom_range(0, 2) == 0);
      wr_num   = 16'($urandom);
      wr_state = {$urandom, $urandom};
      rd_num   = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/thread_state_mp.md
# thread_state_mp

Parametrised multi-port thread-state store for the sha512crypt engine: each of N_THREADS threads holds one STATE_WIDTH-bit state word, written from N_WR independent channels and read from N_RD channels, each read channel individually synchronous or asynchronous. Writes are buffered one-deep per channel and committed one per cycle by fixed priority. On reset, every state word is cleared to zero by an internal sweep. Per-channel overflow detection reports the offending channel.

## Interface
Parameters:
- N_THREADS, 16: number of threads (memory depth), ≥2.
- NUM_W, `MSB(N_THREADS-1)+1`: thread-number width.
- STATE_WIDTH, `THREAD_STATE_MSB+1`: state word width.
- N_WR, 4: write channels, 1..8.
- N_RD, 4: read channels, 1..8.
- RD_ASYNC, 4'b0001: bit r=1 means read channel r is combinational; 0 means registered.
- RD_PER_COPY, 2: read ports served by one memory replica. Replicas = ceil(N_RD/RD_PER_COPY), all written identically.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- wr_en  in  N_WR  write request per channel.
- wr_num  in  N_WR*NUM_W  thread number; channel k at [k*NUM_W +: NUM_W].
- wr_state  in  N_WR*STATE_WIDTH  state word; channel k at [k*STATE_WIDTH +: STATE_WIDTH].
- rd_num  in  N_RD*NUM_W  read address per channel.
- rd_state  out  N_RD*STATE_WIDTH  read data per channel.
- ready  out  1  high once the init sweep has completed.
- err  out  1  sticky error flag.
- err_ch  out  3  channel index of the first overflow; valid when err=1.

## Operation
- Init sweep: RESET sets ready=0, err=0, err_ch=0, all pending flags=0, sweep counter=0, and all registered rd_state=0. While ready=0, each cycle writes 0 to memory[counter] in all replicas and increments the counter. After writing address N_THREADS-1, ready=1 on the next cycle. The sweep takes N_THREADS cycles. RESET asserted mid-sweep or mid-operation restarts the sweep from 0.
- Holding registers: on wr_en[k]=1, channel k latches wr_num/wr_state and sets pending[k]=1.
- Arbiter: when ready=1, grant goes to the lowest k with pending[k]=1. The granted register is written to memory, and pending[k] clears unless wr_en[k] reloads it in the same cycle. At most one commit per cycle.
- Overflow: wr_en[k]=1 while pending[k]=1 and k is not granted this cycle. The new word is dropped, the held word is kept, and err is set. If err was 0, err_ch=k. Lowest k wins if several channels overflow in the same cycle.
- wr_en during ready=0: treated as overflow. The word is dropped, err is set, and err_ch is the channel index. The sweep is unaffected.
- No forwarding: reads return memory contents only. Pending words are not visible. Reads during the sweep return an undefined mix of old and zero contents.
- Same-thread writes from two channels in one cycle: both are buffered. The lower channel commits first and the higher channel's word persists.
- Read with rd_num ≥ N_THREADS (non-power-of-2 depth): data undefined, no error.

## Timing
- Write latency with no contention: wr_en at cycle t, holding register at t+1, committed at the end of t+1. An async read of that thread shows the new value in cycle t+2. A sync read with rd_num applied at t+2 returns it at t+3.
- Under contention, channel k's commit is delayed by one cycle per pending lower-index channel. With all channels loaded, worst case is N_WR cycles.
- Sustained throughput is one write per cycle in aggregate. Any single channel may write every cycle only while it is the highest-priority pending channel.
- Sync read: rd_state[r] registered, 1-cycle latency, reset value 0. Async read: combinational from rd_num[r].
- A read and a commit to the same address in the same cycle: a sync read returns the old word, and an async read shows the new word after the edge.
- ready, err and err_ch are registered. err clears only on RESET.

## Test plan
- Init: N_THREADS=16. Preload memory with nonzero words, assert RESET 1 cycle → ready rises 16 cycles after RESET deasserts, and all 16 threads read 0 on every channel.
- Single write: ch0 writes thread 5 = 0x2A at t → async rd ch0 (rd_num=5) shows 0x2A at t+2. Sync rd ch1 with rd_num=5 applied at t+2 shows 0x2A at t+3.
- Contention: ch0 writes thread 1=0x11, ch1 writes thread 2=0x22 and ch3 writes thread 3=0x33, all at t → commits on t+1, t+2 and t+3 in channel order. err stays 0.
- Same-thread collision: ch0 writes thread 7=0x01 and ch2 writes thread 7=0x02 in the same cycle → final read of thread 7 = 0x02.
- Overflow: ch0 writes on every cycle t..t+2 while ch1 writes at t and t+1 → err=1 and err_ch=1. The ch1 word from t+1 is dropped, and the ch1 word from t is stored.
- Reset mid-sweep: RESET asserted at sweep count 9 → sweep restarts, ready rises 16 cycles later, and err is 0.
